lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
- Load/store unit directly downstream of the execute ALU: takes the ALU result as the effective address and rs2 as store data, and performs one RV64 load or store per request.
- Drives a simple request/grant/rvalid memory port, aligns byte lanes, and sign- or zero-extends load data.
- Returns one writeback result per request.
- Multi-cycle FSM; the core stalls on req_ready/resp_valid.

Parameters:
- REG_WIDTH, 64, data/address width; only 64 is supported.
- TIMEOUT_CYCLES, 255, cycles to wait for mem_gnt or mem_rvalid before a fault. Used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RISC-V funct3 (size/sign)
- req_addr  in  64  effective address (ALU alu_out)
- req_wdata  in  64  store data (rs2)
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  64  extended load data; 0 for stores and faults
- resp_misaligned  out  1  address not naturally aligned
- resp_illegal  out  1  unsupported funct3
- resp_timeout  out  1  memory timeout (0 unless LSU_TIMEOUT_EN)
- mem_req  out  1  memory request
- mem_we  out  1  write enable
- mem_addr  out  64  doubleword-aligned address, {req_addr[63:3],3'b000}
- mem_wdata  out  64  lane-shifted store data
- mem_be  out  8  byte enables
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  read data valid
- mem_rdata  in  64  read data

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0 except req_ready=1.
  - Reset mid-operation drops mem_req at once.
  - No response is issued for an aborted access.
- States and transitions:
  - IDLE: req_ready=1. Accept on req_valid&&req_ready and latch all req_* fields. Next state is FAULT if the request is misaligned or illegal, else REQ.
  - REQ: mem_req=1 with mem_we/addr/wdata/be held stable until mem_gnt. On gnt, a store goes to DONE and a load goes to WAIT.
  - WAIT: capture mem_rdata on mem_rvalid, then go to DONE. mem_rvalid is ignored in every state except WAIT.
  - DONE/FAULT: resp_valid=1 for exactly one cycle, then IDLE. FAULT never asserts mem_req. The response has no backpressure.
- Latency (accept edge = T):
  - load with immediate gnt and rvalid: resp_valid in cycle T+3
  - store with immediate gnt: T+2
  - fault: T+1
- funct3 decoding:
  - Loads: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU. 111 is illegal.
  - Stores: 000 SB, 001 SH, 010 SW, 011 SD. 1xx is illegal.
- Alignment:
  - size = 1, 2, 4 or 8 bytes.
  - Misaligned when req_addr mod size != 0.
  - If both illegal and misaligned apply, only resp_illegal is set.
- Byte lanes: off = req_addr[2:0].
  - mem_be = ((1<<size)-1) << off.
  - mem_wdata = req_wdata << (8*off); bytes outside mem_be are don't-care but driven deterministically.
- Loads:
  - raw = mem_rdata >> (8*off), truncated to size.
  - Sign-extend for LB/LH/LW; zero-extend for LBU/LHU/LWU; LD passes through.
- Output timing:
  - resp_rdata and the fault flags are valid only while resp_valid=1 and are 0 otherwise.
  - mem_* outputs are 0 when mem_req=0.
- Back-to-back: a new request can be accepted in the IDLE cycle right after DONE. There is no overlap between requests.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- With the macro defined:
  - An 8+ bit counter clears on entering REQ or WAIT and increments each cycle spent there.
  - When it reaches TIMEOUT_CYCLES without gnt or rvalid, mem_req drops and the FSM goes to FAULT with resp_timeout=1.
  - A late mem_rvalid after the timeout is ignored.
- Without the macro: no counter logic; the FSM waits indefinitely and resp_timeout is tied to 0.

Test Plan:
- Reset: rst_n low for 3 cycles, then high -> req_ready=1 and all other outputs 0. Assert rst_n mid-WAIT -> mem_req=0 immediately and no resp_valid.
- LB at addr 0x1003 with mem_rdata=0x0000_0000_8000_0000, immediate gnt and rvalid:
  - mem_addr=0x1000, mem_be=0x08
  - resp_valid in cycle T+3, resp_rdata=0xFFFF_FFFF_FFFF_FF80
  - LBU at the same address -> resp_rdata=0x80
- SH at addr 0x2006, req_wdata=0x1234_ABCD, gnt delayed 2 cycles:
  - mem_be=0xC0, mem_wdata[63:48]=0xABCD
  - mem_req held for 3 cycles; resp_valid 1 cycle after gnt
- LW at 0x3002 -> FAULT: resp_valid at T+1, resp_misaligned=1, mem_req never asserted. Store with funct3=101 -> resp_illegal=1.
- LD at 0x4000 with rdata=0xDEAD_BEEF_0123_4567 and rvalid 4 cycles after gnt -> resp_rdata equals rdata exactly. A spurious mem_rvalid during REQ is ignored.
- Under LSU_TIMEOUT_EN with TIMEOUT_CYCLES=8 and mem_gnt held 0 -> mem_req drops after 8 cycles, then resp_valid=1 with resp_timeout=1.

Source files
------------

// File: rtl/lsu_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lsu_mem_stage                                                |
// | Description : RV64 load/store unit with req/gnt/rvalid memory port,        |
// |               byte-lane alignment and load extension.                      |
// |               Optional feature macro: LSU_TIMEOUT_EN (gnt/rvalid timeout). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lsu_mem_stage #(
    parameter int REG_WIDTH      = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [REG_WIDTH-1:0] req_addr,
    input  logic [REG_WIDTH-1:0] req_wdata,
    output logic                 resp_valid,
    output logic [REG_WIDTH-1:0] resp_rdata,
    output logic                 resp_misaligned,
    output logic                 resp_illegal,
    output logic                 resp_timeout,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [REG_WIDTH-1:0] mem_addr,
    output logic [REG_WIDTH-1:0] mem_wdata,
    output logic [7:0]           mem_be,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [REG_WIDTH-1:0] mem_rdata
);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_req   = 3'd1;
    localparam logic [2:0] c_wait  = 3'd2;
    localparam logic [2:0] c_done  = 3'd3;
    localparam logic [2:0] c_fault = 3'd4;

    generate
        if (REG_WIDTH != 64 || TIMEOUT_CYCLES < 1) begin : g_bad_param
            $error("lsu_mem_stage: REG_WIDTH must be 64 and TIMEOUT_CYCLES >= 1");
        end
    endgenerate

    logic [2:0]  r_state;
    logic [2:0]  w_state_next;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [63:0] r_rdata;
    logic        r_misaligned;
    logic        r_illegal;

    logic        w_accept;
    logic        w_req_misaligned;
    logic        w_req_illegal;
    logic [5:0]  w_shift_amt;
    logic [7:0]  w_be_base;
    logic [63:0] w_load_shifted;
    logic [63:0] w_load_ext;

    assign w_accept    = req_valid && (r_state == c_idle);
    assign w_shift_amt = {r_addr[2:0], 3'b000};

    // funct3[1:0] encodes log2(size) for every legal load and store.
    always_comb begin
        w_req_misaligned = 1'b0;
        case (req_funct3[1:0])
            2'b01:   w_req_misaligned = req_addr[0];
            2'b10:   w_req_misaligned = (req_addr[1:0] != 2'b00);
            2'b11:   w_req_misaligned = (req_addr[2:0] != 3'b000);
            default: w_req_misaligned = 1'b0;
        endcase
        w_req_illegal = req_we ? req_funct3[2] : (req_funct3 == 3'b111);
    end

    always_comb begin
        w_be_base = 8'h00;
        case (r_funct3[1:0])
            2'b00:   w_be_base = 8'h01;
            2'b01:   w_be_base = 8'h03;
            2'b10:   w_be_base = 8'h0F;
            default: w_be_base = 8'hFF;
        endcase
    end

    always_comb begin
        w_load_shifted = mem_rdata >> w_shift_amt;
        w_load_ext     = w_load_shifted;
        case (r_funct3)
            3'b000:  w_load_ext = {{56{w_load_shifted[7]}},  w_load_shifted[7:0]};
            3'b001:  w_load_ext = {{48{w_load_shifted[15]}}, w_load_shifted[15:0]};
            3'b010:  w_load_ext = {{32{w_load_shifted[31]}}, w_load_shifted[31:0]};
            3'b100:  w_load_ext = {56'd0, w_load_shifted[7:0]};
            3'b101:  w_load_ext = {48'd0, w_load_shifted[15:0]};
            3'b110:  w_load_ext = {32'd0, w_load_shifted[31:0]};
            default: w_load_ext = w_load_shifted;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int c_tmo_w = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);

    logic [c_tmo_w-1:0] r_tmo_cnt;
    logic               r_timeout;
    logic               w_tmo_hit;
    logic               w_enter_busy;

    assign w_tmo_hit    = (r_tmo_cnt == c_tmo_last);
    assign w_enter_busy = ((w_state_next == c_req) || (w_state_next == c_wait)) &&
                          (w_state_next != r_state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_enter_busy) begin
                r_tmo_cnt <= '0;
            end else if ((r_state == c_req) || (r_state == c_wait)) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            if (w_accept) begin
                r_timeout <= 1'b0;
            end else if (w_state_next == c_fault) begin
                r_timeout <= 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_idle: begin
                if (w_accept) begin
                    w_state_next = (w_req_misaligned || w_req_illegal) ? c_fault : c_req;
                end
            end
            c_req: begin
                if (mem_gnt) begin
                    w_state_next = r_we ? c_done : c_wait;
                end
`ifdef LSU_TIMEOUT_EN
                else if (w_tmo_hit) begin
                    w_state_next = c_fault;
                end
`endif
            end
            c_wait: begin
                if (mem_rvalid) begin
                    w_state_next = c_done;
                end
`ifdef LSU_TIMEOUT_EN
                else if (w_tmo_hit) begin
                    w_state_next = c_fault;
                end
`endif
            end
            c_done:  w_state_next = c_idle;
            c_fault: w_state_next = c_idle;
            default: w_state_next = c_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we         <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_misaligned <= 1'b0;
            r_illegal    <= 1'b0;
        end else if (w_accept) begin
            r_we         <= req_we;
            r_funct3     <= req_funct3;
            r_addr       <= req_addr;
            r_wdata      <= req_wdata;
            r_rdata      <= '0;
            r_misaligned <= w_req_misaligned && !w_req_illegal;
            r_illegal    <= w_req_illegal;
        end else if ((r_state == c_wait) && mem_rvalid) begin
            r_rdata      <= w_load_ext;
        end
    end

    always_comb begin
        req_ready       = (r_state == c_idle);
        mem_req         = (r_state == c_req);
        mem_we          = mem_req && r_we;
        mem_addr        = mem_req ? {r_addr[63:3], 3'b000} : 64'd0;
        mem_wdata       = mem_req ? (r_wdata << w_shift_amt) : 64'd0;
        mem_be          = mem_req ? (w_be_base << r_addr[2:0]) : 8'h00;
        resp_valid      = (r_state == c_done) || (r_state == c_fault);
        resp_rdata      = (r_state == c_done) ? r_rdata : 64'd0;
        resp_misaligned = (r_state == c_fault) && r_misaligned;
        resp_illegal    = (r_state == c_fault) && r_illegal;
`ifdef LSU_TIMEOUT_EN
        resp_timeout    = (r_state == c_fault) && r_timeout;
`else
        resp_timeout    = 1'b0;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_lsu_mem_stage                                             |
// | Description : Directed scoreboard bench for lsu_mem_stage.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_lsu_mem_stage;

`ifdef LSU_TIMEOUT_EN
    localparam int c_tmo = 8;
`else
    localparam int c_tmo = 255;
`endif

    typedef struct packed {
        logic [63:0] rdata;
        logic        mis;
        logic        ill;
        logic        tmo;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_misaligned;
    logic        resp_illegal;
    logic        resp_timeout;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_be;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [63:0] mem_rdata = 64'd0;

    int total = 0;
    int bad   = 0;
    resp_t sb[$];

    lsu_mem_stage #(.REG_WIDTH(64), .TIMEOUT_CYCLES(c_tmo)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_misaligned(resp_misaligned), .resp_illegal(resp_illegal),
        .resp_timeout(resp_timeout),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic resp_t mk(input logic [63:0] rd, input logic mis, input logic ill, input logic tmo);
        resp_t r;
        r.rdata = rd; r.mis = mis; r.ill = ill; r.tmo = tmo;
        return r;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, 64'(req_ready), 64'd1);
        check({tag, "_rvalid"}, 64'(resp_valid), 64'd0);
        check({tag, "_rdata"}, resp_rdata, 64'd0);
        check({tag, "_flags"}, {61'd0, resp_misaligned, resp_illegal, resp_timeout}, 64'd0);
        check({tag, "_memreq"}, 64'(mem_req), 64'd0);
        check({tag, "_membus"}, {63'd0, mem_we} | mem_addr | mem_wdata | {56'd0, mem_be}, 64'd0);
    endtask

    // One full transaction with a scripted memory responder.
    task automatic do_access(input string tag, input logic we, input logic [2:0] f3,
                             input logic [63:0] addr, input logic [63:0] wdata, input logic [63:0] rd,
                             input int gnt_dly, input int rv_dly, input logic spur,
                             input logic [7:0] exp_be, input logic [63:0] exp_wd,
                             input resp_t exp, input int exp_lat, input int exp_req);
        int cyc, reqc, waitc;
        logic granted, seen;
        resp_t got;
        logic [63:0] be_mask;
        check({tag, "_ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        tick();
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 64'd0; req_wdata = 64'd0;
        sb.push_back(exp);
        cyc = 1; reqc = 0; waitc = 0; granted = 1'b0; seen = 1'b0;
        while (!seen && cyc < 400) begin
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'd0;
            if (resp_valid) begin
                seen = 1'b1;
                check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
                check({tag, "_reqcyc"}, 64'(reqc), 64'(exp_req));
                if (sb.size() == 0) begin
                    check({tag, "_sb_empty"}, 64'd0, 64'd1);
                end else begin
                    got = sb.pop_front();
                    check({tag, "_rdata"}, resp_rdata, got.rdata);
                    check({tag, "_flags"}, {61'd0, resp_misaligned, resp_illegal, resp_timeout},
                          {61'd0, got.mis, got.ill, got.tmo});
                end
            end else begin
                if (mem_req) begin
                    if (reqc == 0) begin
                        check({tag, "_addr"}, mem_addr, {addr[63:3], 3'b000});
                        check({tag, "_be"}, 64'(mem_be), 64'(exp_be));
                        check({tag, "_we"}, 64'(mem_we), 64'(we));
                        if (we) begin
                            for (int b = 0; b < 8; b++) be_mask[b*8 +: 8] = {8{exp_be[b]}};
                            check({tag, "_wdata"}, mem_wdata & be_mask, exp_wd);
                        end
                    end
                    reqc++;
                    if (reqc > gnt_dly) begin
                        mem_gnt = 1'b1;
                        granted = 1'b1;
                    end else if (spur) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
                    end
                end else if (granted && !we) begin
                    if (waitc == rv_dly) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = rd;
                    end
                    waitc++;
                end
                tick();
                cyc++;
            end
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'd0;
        if (!seen) check({tag, "_no_resp"}, 64'd0, 64'd1);
        tick();
        check({tag, "_pulse"}, 64'(resp_valid), 64'd0);
        check({tag, "_rdata_idle"}, resp_rdata, 64'd0);
    endtask

    // Abort a load with reset, either while requesting or while waiting for data.
    task automatic do_abort(input string tag, input logic in_wait);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b011; req_addr = 64'h8000;
        tick();
        req_valid = 1'b0; req_funct3 = 3'b000; req_addr = 64'd0;
        check({tag, "_req_on"}, 64'(mem_req), 64'd1);
        if (in_wait) begin
            mem_gnt = 1'b1;
            tick();
            mem_gnt = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check({tag, "_req_drop"}, 64'(mem_req), 64'd0);
        check({tag, "_no_resp0"}, 64'(resp_valid), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) mem_rvalid = 1'b1;
            tick();
            mem_rvalid = 1'b0;
            check({tag, "_no_resp"}, 64'(resp_valid), 64'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("rst_hold");
        rst_n = 1'b1;
        tick();
        check_idle_outputs("rst");

        do_access("lb", 1'b0, 3'b000, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 0, 0, 1'b0,
                  8'h08, 64'd0, mk(64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1'b0, 1'b0), 3, 1);
        do_access("lbu", 1'b0, 3'b100, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 0, 0, 1'b0,
                  8'h08, 64'd0, mk(64'h80, 1'b0, 1'b0, 1'b0), 3, 1);
        do_access("sh", 1'b1, 3'b001, 64'h2006, 64'h1234_ABCD, 64'd0, 2, 0, 1'b0,
                  8'hC0, 64'hABCD_0000_0000_0000, mk(64'd0, 1'b0, 1'b0, 1'b0), 4, 3);
        do_access("lw_mis", 1'b0, 3'b010, 64'h3002, 64'd0, 64'd0, 0, 0, 1'b0,
                  8'h00, 64'd0, mk(64'd0, 1'b1, 1'b0, 1'b0), 1, 0);
        do_access("st_ill", 1'b1, 3'b101, 64'h3000, 64'hFFFF, 64'd0, 0, 0, 1'b0,
                  8'h00, 64'd0, mk(64'd0, 1'b0, 1'b1, 1'b0), 1, 0);
        do_access("st_ill_mis", 1'b1, 3'b101, 64'h3001, 64'hFFFF, 64'd0, 0, 0, 1'b0,
                  8'h00, 64'd0, mk(64'd0, 1'b0, 1'b1, 1'b0), 1, 0);
        do_access("ld_ill", 1'b0, 3'b111, 64'h3000, 64'd0, 64'd0, 0, 0, 1'b0,
                  8'h00, 64'd0, mk(64'd0, 1'b0, 1'b1, 1'b0), 1, 0);
        do_access("ld", 1'b0, 3'b011, 64'h4000, 64'd0, 64'hDEAD_BEEF_0123_4567, 2, 4, 1'b1,
                  8'hFF, 64'd0, mk(64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0, 1'b0), 9, 3);
        do_access("lh", 1'b0, 3'b001, 64'h5006, 64'd0, 64'h8001_0000_0000_0000, 0, 1, 1'b0,
                  8'hC0, 64'd0, mk(64'hFFFF_FFFF_FFFF_8001, 1'b0, 1'b0, 1'b0), 4, 1);
        do_access("lhu", 1'b0, 3'b101, 64'h5006, 64'd0, 64'h8001_0000_0000_0000, 0, 0, 1'b0,
                  8'hC0, 64'd0, mk(64'h8001, 1'b0, 1'b0, 1'b0), 3, 1);
        do_access("lw", 1'b0, 3'b010, 64'h5004, 64'd0, 64'hF000_0000_1234_5678, 0, 0, 1'b0,
                  8'hF0, 64'd0, mk(64'hFFFF_FFFF_F000_0000, 1'b0, 1'b0, 1'b0), 3, 1);
        do_access("lwu", 1'b0, 3'b110, 64'h5004, 64'd0, 64'hF000_0000_1234_5678, 0, 0, 1'b0,
                  8'hF0, 64'd0, mk(64'h0000_0000_F000_0000, 1'b0, 1'b0, 1'b0), 3, 1);
        do_access("sw", 1'b1, 3'b010, 64'h7004, 64'h1122_3344, 64'd0, 0, 0, 1'b0,
                  8'hF0, 64'h1122_3344_0000_0000, mk(64'd0, 1'b0, 1'b0, 1'b0), 2, 1);
        do_access("sd", 1'b1, 3'b011, 64'h6000, 64'h0102_0304_0506_0708, 64'd0, 1, 0, 1'b0,
                  8'hFF, 64'h0102_0304_0506_0708, mk(64'd0, 1'b0, 1'b0, 1'b0), 3, 2);
        do_access("sb", 1'b1, 3'b000, 64'h6005, 64'h0000_00A5, 64'd0, 0, 0, 1'b0,
                  8'h20, 64'h0000_A500_0000_0000, mk(64'd0, 1'b0, 1'b0, 1'b0), 2, 1);

        do_abort("abort_req", 1'b0);
        do_abort("abort_wait", 1'b1);
        check_idle_outputs("post_abort");
        do_access("lb_after", 1'b0, 3'b000, 64'h1000, 64'd0, 64'h0000_0000_0000_007F, 0, 0, 1'b0,
                  8'h01, 64'd0, mk(64'h7F, 1'b0, 1'b0, 1'b0), 3, 1);

`ifdef LSU_TIMEOUT_EN
        do_access("tmo", 1'b0, 3'b011, 64'h9000, 64'd0, 64'd0, 1000, 0, 1'b0,
                  8'hFF, 64'd0, mk(64'd0, 1'b0, 1'b0, 1'b1), 9, 8);
        for (int i = 0; i < 2; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 64'h5555_5555_5555_5555;
            tick();
            check("tmo_late_rvalid", 64'(resp_valid), 64'd0);
        end
        mem_rvalid = 1'b0;
        mem_rdata  = 64'd0;
`endif

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
